// File: rtl/store_write_buffer_pkg.sv
// Shared types and sizing helpers for the store write buffer and its
// forwarding search.
package store_write_buffer_pkg;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_ENTRIES    = 4;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] address;
        logic [DEFAULT_WIDTH-1:0]      data;
    } store_entry_t;

    // Depth is a power of two, so pointers wrap for free at this width.
    function automatic int ptr_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/store_forward_match.sv
// Youngest-match search over the occupied part of the store buffer ring,
// walking from head (oldest) towards tail so later matches win.
module store_forward_match
    import store_write_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ENTRIES    = DEFAULT_ENTRIES,
    parameter int PW         = ptr_width(ENTRIES)
) (
    input  logic [ADDR_WIDTH-1:0] addresses [ENTRIES],
    input  logic [PW-1:0]         head,
    input  logic [PW:0]           count,
    input  logic [ADDR_WIDTH-1:0] load_address,
    output logic                  hit,
    output logic [PW-1:0]         index
);

    logic [PW-1:0] slot;

    always_comb begin
        hit   = 1'b0;
        index = '0;
        slot  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            slot = head + PW'(i);
            if (((PW+1)'(i) < count) && (addresses[slot] == load_address)) begin
                hit   = 1'b1;
                index = slot;
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// FIFO store buffer in front of the data memory write port, with
// load forwarding from the youngest matching pending store.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ENTRIES    = DEFAULT_ENTRIES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  storeValid,
    input  logic [ADDR_WIDTH-1:0] storeAddress,
    input  logic [WIDTH-1:0]      storeData,
    output logic                  bufferFull,
    output logic                  bufferEmpty,
    input  logic                  loadEnable,
    input  logic [ADDR_WIDTH-1:0] loadAddress,
    input  logic [WIDTH-1:0]      memReadData,
    output logic [WIDTH-1:0]      loadData,
    output logic                  loadHit,
    input  logic                  memWriteReady,
    output logic [ADDR_WIDTH-1:0] addressWriteMemory,
    output logic                  enableWriteMemory,
    output logic [WIDTH-1:0]      dataInMemory
);

    localparam int PW = ptr_width(ENTRIES);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] entry_address [ENTRIES];
    logic [WIDTH-1:0]      entry_data    [ENTRIES];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;

    logic          push;
    logic          pop;
    logic          match_hit;
    logic [PW-1:0] match_index;

    // Flags come from registered count only; a pop cannot free room for a
    // push in the same cycle.
    assign bufferFull  = (count == CW'(ENTRIES));
    assign bufferEmpty = (count == '0);
    assign push        = storeValid && !bufferFull;
    assign pop         = !bufferEmpty && memWriteReady;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                entry_address[i] <= '0;
                entry_data[i]    <= '0;
            end
        end else begin
            if (push) begin
                entry_address[tail] <= storeAddress;
                entry_data[tail]    <= storeData;
                tail                <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign enableWriteMemory  = !bufferEmpty;
    assign addressWriteMemory = bufferEmpty ? '0 : entry_address[head];
    assign dataInMemory       = bufferEmpty ? '0 : entry_data[head];

    store_forward_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ENTRIES    (ENTRIES),
        .PW         (PW)
    ) u_match (
        .addresses    (entry_address),
        .head         (head),
        .count        (count),
        .load_address (loadAddress),
        .hit          (match_hit),
        .index        (match_index)
    );

    // The head entry still counts while it is being written out this cycle.
    assign loadHit  = loadEnable && match_hit;
    assign loadData = !loadEnable ? '0
                    : match_hit   ? entry_data[match_index]
                    : memReadData;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: drain order, full handling,
// forwarding priority, reset discard and pointer wrap.
module tb_store_write_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        storeValid;
    logic [31:0] storeAddress;
    logic [31:0] storeData;
    logic        bufferFull;
    logic        bufferEmpty;
    logic        loadEnable;
    logic [31:0] loadAddress;
    logic [31:0] memReadData;
    logic [31:0] loadData;
    logic        loadHit;
    logic        memWriteReady;
    logic [31:0] addressWriteMemory;
    logic        enableWriteMemory;
    logic [31:0] dataInMemory;

    int total = 0;
    int bad   = 0;
    int wr_idx = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    store_write_buffer dut (
        .clock              (clock),
        .reset              (reset),
        .storeValid         (storeValid),
        .storeAddress       (storeAddress),
        .storeData          (storeData),
        .bufferFull         (bufferFull),
        .bufferEmpty        (bufferEmpty),
        .loadEnable         (loadEnable),
        .loadAddress        (loadAddress),
        .memReadData        (memReadData),
        .loadData           (loadData),
        .loadHit            (loadHit),
        .memWriteReady      (memWriteReady),
        .addressWriteMemory (addressWriteMemory),
        .enableWriteMemory  (enableWriteMemory),
        .dataInMemory       (dataInMemory)
    );

    always #5 clock = ~clock;

    // Memory model: inputs settle at posedge+1, so the negedge sees what
    // the next rising edge will commit.
    always @(negedge clock) begin
        if (!reset && enableWriteMemory && memWriteReady)
            got_q.push_back({addressWriteMemory, dataInMemory});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d);
        storeValid   = 1'b1;
        storeAddress = a;
        storeData    = d;
        tick();
        storeValid   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        storeValid = 1'b0; storeAddress = '0; storeData = '0;
        loadEnable = 1'b0; loadAddress = '0; memReadData = '0;
        memWriteReady = 1'b0;
        tick(); tick();
        total++;
        if (bufferEmpty !== 1'b1 || bufferFull !== 1'b0 || enableWriteMemory !== 1'b0 || loadHit !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: empty=%b full=%b en=%b hit=%b, want 1 0 0 0",
                     bufferEmpty, bufferFull, enableWriteMemory, loadHit);
        end
        total++;
        if (addressWriteMemory !== 32'h0 || dataInMemory !== 32'h0) begin
            bad++;
            $display("FAIL reset_drain_zero: addr=%h data=%h, want 0 0", addressWriteMemory, dataInMemory);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_fill();
        memWriteReady = 1'b0;
        push_store(32'h10, 32'hAAAA_0001);
        push_store(32'h11, 32'hAAAA_0002);
        total++;
        if (enableWriteMemory !== 1'b1 || addressWriteMemory !== 32'h10 || dataInMemory !== 32'hAAAA_0001) begin
            bad++;
            $display("FAIL pre_reset_head: en=%b addr=%h data=%h, want 1 10 aaaa0001",
                     enableWriteMemory, addressWriteMemory, dataInMemory);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bufferEmpty !== 1'b1 || enableWriteMemory !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: empty=%b en=%b, want 1 0", bufferEmpty, enableWriteMemory);
        end
        tick();
        reset = 1'b0;
        memWriteReady = 1'b1;
        tick(); tick(); tick();
        memWriteReady = 1'b0;
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL reset_discard: writes=%0d, want %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_fill_and_drain();
        memWriteReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_store(32'h20 + i, 32'hB000_0000 + i);
            exp_q.push_back({32'h20 + i, 32'hB000_0000 + i});
            total++;
            if (bufferFull !== (i == 3)) begin
                bad++;
                $display("FAIL fill_full_%0d: full=%b, want %b", i, bufferFull, (i == 3));
            end
        end
        push_store(32'h24, 32'hB000_0004);
        total++;
        if (bufferFull !== 1'b1 || addressWriteMemory !== 32'h20) begin
            bad++;
            $display("FAIL push_when_full: full=%b head=%h, want 1 20", bufferFull, addressWriteMemory);
        end
        memWriteReady = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        memWriteReady = 1'b0;
        total++;
        if (bufferEmpty !== 1'b1) begin
            bad++;
            $display("FAIL fill_drain_empty: empty=%b, want 1", bufferEmpty);
        end
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL fill_drain_count: writes=%0d, want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int k = wr_idx; k < exp_q.size(); k++) begin
                if (got_q[k] !== exp_q[k]) begin
                    bad++;
                    $display("FAIL fill_drain_order_%0d: got %h, want %h", k, got_q[k], exp_q[k]);
                end
            end
        end
        wr_idx = exp_q.size();
    endtask

    task automatic test_full_with_pop();
        memWriteReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_store(32'h2C + i, 32'hC000_0000 + i);
            exp_q.push_back({32'h2C + i, 32'hC000_0000 + i});
        end
        exp_q.push_back({32'h30, 32'h3030_3030});
        memWriteReady = 1'b1;
        storeValid = 1'b1; storeAddress = 32'h30; storeData = 32'h3030_3030;
        #1;
        total++;
        if (bufferFull !== 1'b1) begin
            bad++;
            $display("FAIL full_before_pop: full=%b, want 1", bufferFull);
        end
        tick();
        total++;
        if (bufferFull !== 1'b0 || addressWriteMemory !== 32'h2D) begin
            bad++;
            $display("FAIL pop_rejects_push: full=%b head=%h, want 0 2d", bufferFull, addressWriteMemory);
        end
        tick();
        storeValid = 1'b0;
        for (int c = 0; c < 10 && !bufferEmpty; c++) tick();
        memWriteReady = 1'b0;
        total++;
        if (bufferEmpty !== 1'b1 || got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL full_pop_drain: empty=%b writes=%0d, want 1 %0d", bufferEmpty, got_q.size(), exp_q.size());
        end else begin
            for (int k = wr_idx; k < exp_q.size(); k++) begin
                if (got_q[k] !== exp_q[k]) begin
                    bad++;
                    $display("FAIL full_pop_order_%0d: got %h, want %h", k, got_q[k], exp_q[k]);
                end
            end
        end
        wr_idx = exp_q.size();
    endtask

    task automatic test_forward_youngest();
        memWriteReady = 1'b0;
        push_store(32'h40, 32'h1111_1111);
        push_store(32'h40, 32'h2222_2222);
        exp_q.push_back({32'h40, 32'h1111_1111});
        exp_q.push_back({32'h40, 32'h2222_2222});
        loadEnable = 1'b1; loadAddress = 32'h40; memReadData = 32'hDEAD_BEEF;
        #1;
        total++;
        if (loadHit !== 1'b1 || loadData !== 32'h2222_2222) begin
            bad++;
            $display("FAIL fwd_youngest: hit=%b data=%h, want 1 22222222", loadHit, loadData);
        end
        loadAddress = 32'h41;
        #1;
        total++;
        if (loadHit !== 1'b0 || loadData !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL fwd_miss: hit=%b data=%h, want 0 deadbeef", loadHit, loadData);
        end
        loadEnable = 1'b0; loadAddress = 32'h40;
        #1;
        total++;
        if (loadHit !== 1'b0 || loadData !== 32'h0) begin
            bad++;
            $display("FAIL no_load: hit=%b data=%h, want 0 0", loadHit, loadData);
        end
        tick();
        memWriteReady = 1'b1;
        tick(); tick();
        memWriteReady = 1'b0;
        total++;
        if (bufferEmpty !== 1'b1 || got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL fwd_drain: empty=%b writes=%0d, want 1 %0d", bufferEmpty, got_q.size(), exp_q.size());
        end
        wr_idx = exp_q.size();
    endtask

    task automatic test_forward_during_drain();
        memWriteReady = 1'b0;
        push_store(32'h50, 32'h5555_5555);
        exp_q.push_back({32'h50, 32'h5555_5555});
        memWriteReady = 1'b1;
        loadEnable = 1'b1; loadAddress = 32'h50; memReadData = 32'h1234_5678;
        #1;
        total++;
        if (loadHit !== 1'b1 || loadData !== 32'h5555_5555) begin
            bad++;
            $display("FAIL fwd_popping_head: hit=%b data=%h, want 1 55555555", loadHit, loadData);
        end
        tick();
        total++;
        if (loadHit !== 1'b0 || loadData !== 32'h1234_5678 || bufferEmpty !== 1'b1) begin
            bad++;
            $display("FAIL after_drain_load: hit=%b data=%h empty=%b, want 0 12345678 1",
                     loadHit, loadData, bufferEmpty);
        end
        loadEnable = 1'b0;
        memWriteReady = 1'b0;
        wr_idx = exp_q.size();
    endtask

    task automatic test_pointer_wrap();
        int model_cnt;
        int i;
        logic acc;
        logic pp;
        model_cnt = 0;
        i = 0;
        for (int n = 0; n < 10; n++) exp_q.push_back({32'h70 + n, 32'hC0DE_0000 + n});
        for (int cyc = 0; cyc < 60 && i < 10; cyc++) begin
            storeValid = 1'b1;
            storeAddress = 32'h70 + i;
            storeData = 32'hC0DE_0000 + i;
            memWriteReady = (cyc % 2 == 0);
            acc = (model_cnt < 4);
            pp = (model_cnt > 0) && memWriteReady;
            model_cnt = model_cnt + (acc ? 1 : 0) - (pp ? 1 : 0);
            tick();
            if (acc) i++;
            total++;
            if (bufferFull !== (model_cnt == 4) || bufferEmpty !== (model_cnt == 0)) begin
                bad++;
                $display("FAIL wrap_flags_%0d: full=%b empty=%b, want cnt=%0d", cyc, bufferFull, bufferEmpty, model_cnt);
            end
        end
        storeValid = 1'b0;
        memWriteReady = 1'b1;
        for (int c = 0; c < 12 && !bufferEmpty; c++) tick();
        memWriteReady = 1'b0;
        total++;
        if (i !== 10 || bufferEmpty !== 1'b1 || got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL wrap_drain: accepted=%0d empty=%b writes=%0d, want 10 1 %0d",
                     i, bufferEmpty, got_q.size(), exp_q.size());
        end else begin
            for (int k = wr_idx; k < exp_q.size(); k++) begin
                if (got_q[k] !== exp_q[k]) begin
                    bad++;
                    $display("FAIL wrap_order_%0d: got %h, want %h", k, got_q[k], exp_q[k]);
                end
            end
        end
        wr_idx = exp_q.size();
    endtask

    initial begin
        test_reset();
        test_reset_mid_fill();
        test_fill_and_drain();
        test_full_with_pop();
        test_forward_youngest();
        test_forward_during_drain();
        test_pointer_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
